// File: rtl/am29_clk_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : am29_clk_pkg                                               |
// | Purpose : shared helpers for the am2925_gen microcycle clock family  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package am29_clk_pkg;

    function automatic int cnt_width(input int lw, input int nph);
        return $clog2((1 << lw) + nph + 1);
    endfunction

    // Bit k < nph-1 falls one state earlier per step; the top phase rises in state 2.
    function automatic logic [31:0] phase_pattern(input int s, input int n, input int nph);
        logic [31:0] p;
        p = '0;
        for (int k = 0; k < 32; k++) begin
            if (k < nph - 1)
                p[k] = (s <= n - 1 - k);
            else if (k == nph - 1)
                p[k] = (s >= 2);
        end
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/am2925_sstep.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : am2925_sstep                                               |
// | Purpose : single-step switch debounce, synchronizer and edge pulse   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module am2925_sstep (
    input  logic clk,
    input  logic rst_n,
    input  logic i_ssnc,
    input  logic i_ssno,
    output logic o_step
);

    logic       r_latch;
    logic [1:0] r_sync;
    logic       r_prev;

    // SR latch on the two switch contacts; a bouncing contact only ever
    // passes through the hold combinations, so the output changes once.
    always_latch begin
        if (!rst_n)
            r_latch <= 1'b0;
        else if (i_ssnc && !i_ssno)
            r_latch <= 1'b1;
        else if (!i_ssnc && i_ssno)
            r_latch <= 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], r_latch};
            r_prev <= r_sync[1];
        end
    end

    assign o_step = r_sync[1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/am2925_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : am2925_gen                                                 |
// | Purpose : programmable-length staggered phase microcycle generator   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module am2925_gen
    import am29_clk_pkg::*;
#(
    parameter int NPH = 4,
    parameter int LW  = 3,
    parameter int NW  = 1
) (
    input  logic          clkin,
    input  logic          init_,
    input  logic [LW-1:0] len,
    input  logic          firstlast_,
    input  logic          halt_,
    input  logic          run_,
    input  logic          ssnc,
    input  logic          ssno,
    input  logic [NW-1:0] waitreq_,
    input  logic [NW-1:0] ready_,
    input  logic          cx,
    output logic          f0,
    output logic [NPH-1:0] c,
    output logic          waitack_,
    output logic          cyc_first,
    output logic          halted
);

    localparam int              c_sw  = cnt_width(LW, NPH);
    localparam logic [c_sw-1:0] c_nph = c_sw'(NPH);
    localparam logic [c_sw-1:0] c_one = c_sw'(1);

    logic [c_sw-1:0] r_s;
    logic [c_sw-1:0] r_nreg;
    logic [c_sw-1:0] w_s_next;
    logic [c_sw-1:0] w_n_next;
    logic [NW-1:0]   r_wait;
    logic [NPH-1:0]  r_c;
    logic            r_halt;
    logic            r_step;
    logic            r_halted;
    logic            r_cyc_first;
    logic            w_step_pulse;
    logic            w_freeze;
    logic            w_at_hp;
    logic            w_go;
    logic            w_stop;

    am2925_sstep u_sstep (
        .clk    (clkin),
        .rst_n  (init_),
        .i_ssnc (ssnc),
        .i_ssno (ssno),
        .o_step (w_step_pulse)
    );

    assign w_freeze = (|r_wait) & ~cx;
    assign w_at_hp  = r_halt & (firstlast_ ? (r_s == c_one) : (r_s == r_nreg));
    // A fresh pulse releases the halt point on the same edge it appears.
    assign w_go     = r_step | w_step_pulse;
    assign w_stop   = w_freeze | (w_at_hp & ~w_go);

    always_comb begin
        w_s_next = r_s;
        w_n_next = r_nreg;
        if (!w_stop) begin
            if (r_s == r_nreg) begin
                w_s_next = c_one;
                w_n_next = c_sw'(len) + c_nph;
            end else begin
                w_s_next = r_s + c_one;
            end
        end
    end

    always_ff @(posedge clkin or negedge init_) begin
        if (!init_) begin
            r_s         <= c_nph;
            r_nreg      <= c_nph;
            r_wait      <= '0;
            r_halt      <= 1'b0;
            r_step      <= 1'b0;
            r_halted    <= 1'b0;
            r_cyc_first <= 1'b0;
            r_c         <= NPH'(phase_pattern(NPH, NPH, NPH));
        end else begin
            r_s         <= w_s_next;
            r_nreg      <= w_n_next;
            r_wait      <= (r_wait | ~waitreq_) & ready_;
            if (!run_)
                r_halt <= 1'b0;
            else if (!halt_)
                r_halt <= 1'b1;
            // Step is consumed only when the halt point is actually left.
            if (!r_halt || (w_at_hp && !w_freeze))
                r_step <= 1'b0;
            else if (w_step_pulse)
                r_step <= 1'b1;
            r_halted    <= w_at_hp & ~w_go;
            r_cyc_first <= (w_s_next == c_one);
            r_c         <= NPH'(phase_pattern(int'(w_s_next), int'(w_n_next), NPH));
        end
    end

    assign f0        = clkin;
    assign c         = r_c;
    assign waitack_  = ~w_freeze;
    assign cyc_first = r_cyc_first;
    assign halted    = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_am2925_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_am2925_gen                                              |
// | Purpose : scoreboard bench for am2925_gen (NPH=4, LW=3, NW=2)        |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_am2925_gen;

    logic       clkin = 1'b0;
    logic       init_;
    logic [2:0] len;
    logic       firstlast_;
    logic       halt_;
    logic       run_;
    logic       ssnc;
    logic       ssno;
    logic [1:0] waitreq_;
    logic [1:0] ready_;
    logic       cx;
    logic       f0;
    logic [3:0] c;
    logic       waitack_;
    logic       cyc_first;
    logic       halted;

    am2925_gen #(.NPH(4), .LW(3), .NW(2)) dut (
        .clkin      (clkin),
        .init_      (init_),
        .len        (len),
        .firstlast_ (firstlast_),
        .halt_      (halt_),
        .run_       (run_),
        .ssnc       (ssnc),
        .ssno       (ssno),
        .waitreq_   (waitreq_),
        .ready_     (ready_),
        .cx         (cx),
        .f0         (f0),
        .c          (c),
        .waitack_   (waitack_),
        .cyc_first  (cyc_first),
        .halted     (halted)
    );

    always #5 clkin = ~clkin;

    typedef struct {
        logic [7:0] v;
        string      nm;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_pass  = 0;
    int   n_total = 0;

    // Monitor: one output sample per clock, just after the rising edge.
    always begin
        @(posedge clkin);
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_total++;
            if ({f0, c, cyc_first, halted, waitack_} === mon_e.v)
                n_pass++;
            else
                $display("FAIL %s: got f0=%b c=%b cf=%b h=%b wa=%b, expected f0=%b c=%b cf=%b h=%b wa=%b",
                         mon_e.nm, f0, c, cyc_first, halted, waitack_,
                         mon_e.v[7], mon_e.v[6:3], mon_e.v[2], mon_e.v[1], mon_e.v[0]);
        end
    end

    // Push the outputs expected after the next edge, then move past it.
    task automatic exp(input logic [3:0] ec, input logic ecf, input logic eh,
                       input logic ewa, input string nm);
        exp_t e;
        e.v  = {1'b1, ec, ecf, eh, ewa};
        e.nm = nm;
        sb.push_back(e);
        @(posedge clkin);
        #2;
    endtask

    task automatic cyc4(input string nm);
        exp(4'b0111, 1'b1, 1'b0, 1'b1, {nm, "_s1"});
        exp(4'b1011, 1'b0, 1'b0, 1'b1, {nm, "_s2"});
        exp(4'b1001, 1'b0, 1'b0, 1'b1, {nm, "_s3"});
        exp(4'b1000, 1'b0, 1'b0, 1'b1, {nm, "_s4"});
    endtask

    logic [1:0] bnc [6] = '{2'b00, 2'b01, 2'b11, 2'b01, 2'b00, 2'b01};

    initial begin
        init_ = 1'b0; len = 3'd0; firstlast_ = 1'b1; halt_ = 1'b1; run_ = 1'b1;
        ssnc = 1'b0; ssno = 1'b1; waitreq_ = 2'b11; ready_ = 2'b11; cx = 1'b0;
        @(posedge clkin);
        #2;

        // Reset and the basic 4-state cycle
        exp(4'b1000, 1'b0, 1'b0, 1'b1, "reset");
        init_ = 1'b1;
        cyc4("len0_a");
        cyc4("len0_b");

        // Length change mid-cycle takes effect only at the cycle boundary
        exp(4'b0111, 1'b1, 1'b0, 1'b1, "len_cur_s1");
        len = 3'd5;
        exp(4'b1011, 1'b0, 1'b0, 1'b1, "len_cur_s2");
        exp(4'b1001, 1'b0, 1'b0, 1'b1, "len_cur_s3");
        exp(4'b1000, 1'b0, 1'b0, 1'b1, "len_cur_s4");
        exp(4'b0111, 1'b1, 1'b0, 1'b1, "len9_s1");
        for (int i = 2; i <= 6; i++)
            exp(4'b1111, 1'b0, 1'b0, 1'b1, $sformatf("len9_s%0d", i));
        exp(4'b1011, 1'b0, 1'b0, 1'b1, "len9_s7");
        len = 3'd0;
        exp(4'b1001, 1'b0, 1'b0, 1'b1, "len9_s8");
        exp(4'b1000, 1'b0, 1'b0, 1'b1, "len9_s9");
        exp(4'b0111, 1'b1, 1'b0, 1'b1, "len4_back_s1");

        // Halt in state 1
        halt_ = 1'b0;
        exp(4'b1011, 1'b0, 1'b0, 1'b1, "halt_req");
        halt_ = 1'b1;
        exp(4'b1001, 1'b0, 1'b0, 1'b1, "halt_s3");
        exp(4'b1000, 1'b0, 1'b0, 1'b1, "halt_s4");
        exp(4'b0111, 1'b1, 1'b0, 1'b1, "halt_arrive");
        exp(4'b0111, 1'b1, 1'b1, 1'b1, "halt_stop");
        exp(4'b0111, 1'b1, 1'b1, 1'b1, "halt_hold");
        run_ = 1'b0;
        exp(4'b0111, 1'b1, 1'b1, 1'b1, "run_edge");
        run_ = 1'b1;
        exp(4'b1011, 1'b0, 1'b0, 1'b1, "run_resume");
        exp(4'b1001, 1'b0, 1'b0, 1'b1, "run_s3");
        exp(4'b1000, 1'b0, 1'b0, 1'b1, "run_s4");

        // Halt in state N, bounce, then one debounced single step
        firstlast_ = 1'b0;
        halt_      = 1'b0;
        exp(4'b0111, 1'b1, 1'b0, 1'b1, "hl_s1");
        halt_ = 1'b1;
        exp(4'b1011, 1'b0, 1'b0, 1'b1, "hl_s2");
        exp(4'b1001, 1'b0, 1'b0, 1'b1, "hl_s3");
        exp(4'b1000, 1'b0, 1'b0, 1'b1, "hl_arrive");
        exp(4'b1000, 1'b0, 1'b1, 1'b1, "hl_stop");
        for (int i = 0; i < 6; i++) begin
            {ssnc, ssno} = bnc[i];
            exp(4'b1000, 1'b0, 1'b1, 1'b1, $sformatf("bounce_%0d", i));
        end
        {ssnc, ssno} = 2'b10;
        exp(4'b1000, 1'b0, 1'b1, 1'b1, "press_e1");
        {ssnc, ssno} = 2'b11;
        exp(4'b1000, 1'b0, 1'b1, 1'b1, "press_e2");
        {ssnc, ssno} = 2'b10;
        exp(4'b0111, 1'b1, 1'b0, 1'b1, "step_s1");
        {ssnc, ssno} = 2'b00;
        exp(4'b1011, 1'b0, 1'b0, 1'b1, "step_s2");
        exp(4'b1001, 1'b0, 1'b0, 1'b1, "step_s3");
        exp(4'b1000, 1'b0, 1'b0, 1'b1, "step_s4");
        exp(4'b1000, 1'b0, 1'b1, 1'b1, "step_done");
        {ssnc, ssno} = 2'b01;
        exp(4'b1000, 1'b0, 1'b1, 1'b1, "release_a");
        exp(4'b1000, 1'b0, 1'b1, 1'b1, "release_b");
        exp(4'b1000, 1'b0, 1'b1, 1'b1, "release_c");
        run_ = 1'b0;
        exp(4'b1000, 1'b0, 1'b1, 1'b1, "run2_edge");
        run_ = 1'b1;
        exp(4'b0111, 1'b1, 1'b0, 1'b1, "run2_resume");

        // Wait channel 1 with cx masking and ready clearing
        waitreq_ = 2'b01;
        exp(4'b1011, 1'b0, 1'b0, 1'b0, "wait_set");
        waitreq_ = 2'b11;
        exp(4'b1011, 1'b0, 1'b0, 1'b0, "wait_frz1");
        exp(4'b1011, 1'b0, 1'b0, 1'b0, "wait_frz2");
        cx = 1'b1;
        exp(4'b1001, 1'b0, 1'b0, 1'b1, "cx_mask_s3");
        exp(4'b1000, 1'b0, 1'b0, 1'b1, "cx_mask_s4");
        cx = 1'b0;
        exp(4'b1000, 1'b0, 1'b0, 1'b0, "cx_unmask");
        ready_ = 2'b01;
        exp(4'b1000, 1'b0, 1'b0, 1'b1, "ready_clr");
        ready_ = 2'b11;
        exp(4'b0111, 1'b1, 1'b0, 1'b1, "wait_resume");

        // Reset at state 3 of a 9-state cycle; ready wins over waitreq
        len = 3'd5;
        exp(4'b1011, 1'b0, 1'b0, 1'b1, "f_s2");
        exp(4'b1001, 1'b0, 1'b0, 1'b1, "f_s3");
        exp(4'b1000, 1'b0, 1'b0, 1'b1, "f_s4");
        exp(4'b0111, 1'b1, 1'b0, 1'b1, "f9_s1");
        exp(4'b1111, 1'b0, 1'b0, 1'b1, "f9_s2");
        exp(4'b1111, 1'b0, 1'b0, 1'b1, "f9_s3");
        init_    = 1'b0;
        waitreq_ = 2'b10;
        ready_   = 2'b10;
        #1;
        n_total++;
        if (c === 4'b1000)
            n_pass++;
        else
            $display("FAIL areset_c_immediate: got c=%b, expected 1000", c);
        n_total++;
        if (halted === 1'b0)
            n_pass++;
        else
            $display("FAIL areset_halted_immediate: got halted=%b, expected 0", halted);
        n_total++;
        if (waitack_ === 1'b1)
            n_pass++;
        else
            $display("FAIL areset_waitack_immediate: got waitack_=%b, expected 1", waitack_);
        exp(4'b1000, 1'b0, 1'b0, 1'b1, "areset_hold");
        init_ = 1'b1;
        len   = 3'd0;
        exp(4'b0111, 1'b1, 1'b0, 1'b1, "rdywin_s1");
        exp(4'b1011, 1'b0, 1'b0, 1'b1, "rdywin_s2");
        waitreq_ = 2'b11;
        ready_   = 2'b11;
        exp(4'b1001, 1'b0, 1'b0, 1'b1, "pre_pulse_s3");

        // Reset pulse entirely between edges must still take effect
        init_ = 1'b0;
        #2;
        init_ = 1'b1;
        n_total++;
        if (f0 === clkin)
            n_pass++;
        else
            $display("FAIL f0_follows_clkin: got f0=%b, clkin=%b", f0, clkin);
        exp(4'b0111, 1'b1, 1'b0, 1'b1, "async_pulse");
        exp(4'b1011, 1'b0, 1'b0, 1'b1, "post_pulse");

        if (n_pass != n_total)
            $display("FAIL summary: %0d of %0d checks failed", n_total - n_pass, n_total);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
`default_nettype wire
